mmu_bus_bridge: RTL and testbench
=================================

Name: mmu_bus_bridge

Overview:
Multi-channel memory access controller between CPUCore requesters (e.g. instruction fetch and data) and the single external data bus. It arbitrates among NUM_CH requesters and translates the winner's virtual address through the MMU, or bypasses translation for kseg0/kseg1. It then runs one external bus transaction and returns the data or a fault code to the granted channel. It is the parametrised successor of the single-channel S_IDLE/S_CONVERT_ADDR sequencer inside the CPU top level.

Parameters:
NUM_CH, 2, number of requester channels; channel 0 has reset round-robin priority.
ADDR_W, 32, virtual/physical address width.
DATA_W, 32, data width.
AT_W, 3, access-type width; value 0 = no access; encoding matches DataBus.vh.
TIMEOUT, 255, maximum S_BUS cycles before a bus-timeout fault; range 1..1023.
KSEG_BYPASS, 1, when 1 and ADDR_W==32, vAddr[31:30]==2'b10 skips the MMU and uses pAddr = vAddr & 32'h1FFFFFFF.

Ports:
clk  in  1  system clock, rising edge.
res  in  1  reset; asynchronous, active-low.
ch_accessType  in  NUM_CH*AT_W  per-channel request; nonzero = request.
ch_addr  in  NUM_CH*ADDR_W  per-channel virtual address.
ch_dataOut  in  NUM_CH*DATA_W  per-channel write data.
ch_dataIn  out  DATA_W  registered read data, shared by all channels.
ch_ready  out  NUM_CH  one-cycle completion pulse, one-hot.
ch_fault  out  NUM_CH  one-cycle fault pulse, one-hot.
ch_faultCode  out  2  0 TLB miss, 1 TLB modified, 2 TLB invalid, 3 bus timeout; valid with ch_fault.
mmu_vAddr  out  ADDR_W  address to MMU.
mmu_addrValid  out  1  translation request.
mmu_pAddr  in  ADDR_W  translated address.
mmu_ready  in  1  translation complete.
mmu_tlbMiss, mmu_tlbModified, mmu_tlbInvalid  in  1 each  MMU fault flags; sampled only with mmu_ready.
db_addr  out  ADDR_W  physical address to bus.
db_dataOut  out  DATA_W  write data to bus.
db_dataIn  in  DATA_W  read data from bus.
db_ready  in  1  bus transaction complete.
db_accessType  out  AT_W  bus access type; 0 = idle.
busy  out  1  high in any state except S_IDLE.

Behaviour:
- Reset (res=0, asynchronous): state S_IDLE; all outputs 0; round-robin pointer = 0; timeout counter = 0. Reset asserted mid-transaction abandons it with no ready or fault pulse.
- S_IDLE: if any channel has nonzero accessType, grant the first requester at or after the RR pointer (wrapping NUM_CH-1 -> 0). Latch grant, vAddr, accessType and write data into registers, then go to S_CONVERT_ADDR. Otherwise stay. The RR pointer becomes grant+1 mod NUM_CH.
- S_CONVERT_ADDR:
  - Bypass address (KSEG_BYPASS): form pAddr combinationally, keep mmu_addrValid 0, and go to S_BUS next cycle.
  - Otherwise: drive mmu_addrValid=1 and mmu_vAddr = latched vAddr until mmu_ready.
  - On mmu_ready with a fault flag set: pulse ch_fault[grant] and go to S_IDLE. Code priority is miss > invalid > modified.
  - On mmu_ready with no fault: latch mmu_pAddr and go to S_BUS.
  - If the granted channel's accessType drops to 0 before mmu_ready: abort to S_IDLE with no pulse and mmu_addrValid deasserted.
- S_BUS: drive db_addr, db_accessType and db_dataOut from registers, held stable.
  - On db_ready: latch db_dataIn into ch_dataIn, set db_accessType to 0, go to S_DONE.
  - The counter increments each S_BUS cycle. On reaching TIMEOUT without db_ready: fault code 3, db_accessType to 0, go to S_IDLE.
  - No abort is possible in S_BUS.
- S_DONE: ch_ready[grant]=1 for exactly one cycle, then S_IDLE.
- ch_dataIn holds its value until the next completed read.
- Requester protocol: hold the request until ready or fault is seen; deassert or change it in the cycle after the pulse. The S_DONE->S_IDLE spacing guarantees no duplicate grant.
- Minimum latency from request to ready pulse: 4 cycles (idle/grant, convert, bus with db_ready same cycle, done). For a faulted access, ch_fault pulses during the cycle after the detecting state.
- Simultaneous requests: exactly one grant per transaction. Fairness: every pending channel is served within NUM_CH transactions.

Decomposition:
- Shared package/header (mmu.vh): state encodings S_IDLE, S_CONVERT_ADDR, S_BUS, S_DONE as `BRIDGE_STATE_T; fault-code constants FAULT_TLB_MISS/MODIFIED/INVALID/BUS_TIMEOUT.
- `MEM_ACCESS_T and the zero access encoding stay in DataBus.vh.
- One sub-module: rr_arbiter (NUM_CH request vector, pointer -> one-hot grant plus index).

Test Plan:
- Single read, ch0 addr 0x00400000, MMU returns 0x00001000 after 2 cycles, db_ready after 1 -> db_addr 0x00001000, ch_dataIn = bus data, ch_ready[0] one pulse, 5 cycles total.
- ch0 and ch1 request together three times back-to-back -> grants 0,1,0; ch1 then served next; never two ready pulses in one cycle.
- ch1 write to 0x80001234 with KSEG_BYPASS=1 -> mmu_addrValid stays 0, db_addr 0x00001234, db_dataOut = ch1 data.
- mmu_ready with tlbMiss and tlbModified both set -> ch_fault[grant], ch_faultCode=0, db_accessType never nonzero.
- db_ready withheld with TIMEOUT=8 -> after 8 S_BUS cycles ch_faultCode=3, db_accessType 0, busy falls.
- Reset pulse asserted in S_BUS, and separately requester drop in S_CONVERT_ADDR -> state S_IDLE with all outputs 0, no ready/fault pulse.

Source files
------------

// File: rtl/mmu_bus_bridge_pkg.sv
// Shared types and constants for the multi-channel MMU bus bridge.
// Holds sequencer state encodings and requester-visible fault codes.
package mmu_bus_bridge_pkg;

  typedef logic [1:0] bridge_state_t;

  localparam bridge_state_t S_IDLE         = 2'd0;
  localparam bridge_state_t S_CONVERT_ADDR = 2'd1;
  localparam bridge_state_t S_BUS          = 2'd2;
  localparam bridge_state_t S_DONE         = 2'd3;

  localparam logic [1:0] FAULT_TLB_MISS     = 2'd0;
  localparam logic [1:0] FAULT_TLB_MODIFIED = 2'd1;
  localparam logic [1:0] FAULT_TLB_INVALID  = 2'd2;
  localparam logic [1:0] FAULT_BUS_TIMEOUT  = 2'd3;

  // Access types with this bit set are stores; others are loads.
  localparam int AT_WR_BIT = 2;

  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  function automatic logic [1:0] tlb_code(
    input logic miss,
    input logic inv
  );
    if (miss)     return FAULT_TLB_MISS;
    else if (inv) return FAULT_TLB_INVALID;
    else          return FAULT_TLB_MODIFIED;
  endfunction

endpackage

// File: rtl/mmu_bus_bridge_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [IDX_W:0]      w_sum;

  always_comb begin
    w_dbl   = {i_req, i_req} >> i_ptr;
    w_rot   = w_dbl[NUM_CH-1:0];
    o_valid = |w_rot;
    w_sum   = '0;
    // Walk downward so the lowest rotated position wins.
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (w_rot[j]) w_sum = {1'b0, i_ptr} + (IDX_W+1)'(j);
    end
    if (w_sum >= (IDX_W+1)'(NUM_CH))
      w_sum = w_sum - (IDX_W+1)'(NUM_CH);
    o_idx = w_sum[IDX_W-1:0];
    o_gnt = o_valid ? (NUM_CH'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/mmu_bus_bridge.sv
// Arbitrates NUM_CH requesters, translates via MMU (or kseg bypass),
// runs one external bus transaction and returns data or a fault.
module mmu_bus_bridge
  import mmu_bus_bridge_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int AT_W        = 3,
  parameter int TIMEOUT     = 255,
  parameter int KSEG_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_CH*AT_W-1:0]   ch_accessType,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_dataOut,
  output logic [DATA_W-1:0]        ch_dataIn,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_fault,
  output logic [1:0]               ch_faultCode,
  output logic [ADDR_W-1:0]        mmu_vAddr,
  output logic                     mmu_addrValid,
  input  logic [ADDR_W-1:0]        mmu_pAddr,
  input  logic                     mmu_ready,
  input  logic                     mmu_tlbMiss,
  input  logic                     mmu_tlbModified,
  input  logic                     mmu_tlbInvalid,
  output logic [ADDR_W-1:0]        db_addr,
  output logic [DATA_W-1:0]        db_dataOut,
  input  logic [DATA_W-1:0]        db_dataIn,
  input  logic                     db_ready,
  output logic [AT_W-1:0]          db_accessType,
  output logic                     busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = 10;

  bridge_state_t     r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_CH-1:0] r_gnt;
  logic [ADDR_W-1:0] r_vaddr;
  logic [ADDR_W-1:0] r_paddr;
  logic [AT_W-1:0]   r_at;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_fault;
  logic [1:0]        r_code;

  logic [AT_W-1:0]   w_at   [NUM_CH];
  logic [ADDR_W-1:0] w_addr [NUM_CH];
  logic [DATA_W-1:0] w_wd   [NUM_CH];
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  logic [IDX_W-1:0]  w_nptr;
  logic              w_cur;
  logic              w_bypass;
  logic              w_mmu_flt;
  logic              w_tmo;
  logic              w_bus;

  // A channel whose fault is pulsing still holds its request this cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_at[c]   = ch_accessType[c*AT_W +: AT_W];
      w_addr[c] = ch_addr[c*ADDR_W +: ADDR_W];
      w_wd[c]   = ch_dataOut[c*DATA_W +: DATA_W];
      w_req[c]  = (|w_at[c]) & ~r_fault[c];
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_nptr = (w_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
  assign w_cur  = |w_at[r_idx];
  assign w_bypass = (KSEG_BYPASS != 0) && (ADDR_W == 32)
                 && (r_vaddr[ADDR_W-1 -: 2] == 2'b10);
  assign w_mmu_flt = mmu_tlbMiss | mmu_tlbModified | mmu_tlbInvalid;
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_bus = (r_state == S_BUS);

  assign mmu_addrValid = (r_state == S_CONVERT_ADDR) && !w_bypass && w_cur;
  assign mmu_vAddr     = mmu_addrValid ? r_vaddr : '0;
  assign db_addr       = w_bus ? r_paddr : '0;
  assign db_dataOut    = w_bus ? r_wdata : '0;
  assign db_accessType = w_bus ? r_at : '0;
  assign ch_ready      = (r_state == S_DONE) ? r_gnt : '0;
  assign ch_fault      = r_fault;
  assign ch_faultCode  = r_code;
  assign ch_dataIn     = r_rdata;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_vaddr <= '0;
      r_paddr <= '0;
      r_at    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_fault <= '0;
      r_code  <= '0;
    end else begin
      r_fault <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_idx   <= w_idx;
            r_gnt   <= w_gnt;
            r_vaddr <= w_addr[w_idx];
            r_at    <= w_at[w_idx];
            r_wdata <= w_wd[w_idx];
            r_ptr   <= w_nptr;
            r_state <= S_CONVERT_ADDR;
          end
        end
        S_CONVERT_ADDR: begin
          if (!w_cur) begin
            r_state <= S_IDLE;
          end else if (w_bypass) begin
            r_paddr <= r_vaddr & ADDR_W'(KSEG_MASK);
            r_cnt   <= '0;
            r_state <= S_BUS;
          end else if (mmu_ready) begin
            if (w_mmu_flt) begin
              r_fault <= r_gnt;
              r_code  <= tlb_code(mmu_tlbMiss, mmu_tlbInvalid);
              r_state <= S_IDLE;
            end else begin
              r_paddr <= mmu_pAddr;
              r_cnt   <= '0;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (db_ready) begin
            if (!r_at[AT_WR_BIT]) r_rdata <= db_dataIn;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_fault <= r_gnt;
            r_code  <= FAULT_BUS_TIMEOUT;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_bus_bridge.sv
// Directed bench for mmu_bus_bridge with a reactive MMU/bus responder.
// Expected values are hand-computed cycle counts, addresses and codes.
module tb_mmu_bus_bridge;

  localparam logic [2:0] AT_RD = 3'd1;
  localparam logic [2:0] AT_WR = 3'd5;

  logic        clk = 1'b0;
  logic        res;
  logic [2:0]  at   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];

  logic [5:0]  ch_accessType;
  logic [63:0] ch_addr;
  logic [63:0] ch_dataOut;
  logic [31:0] ch_dataIn;
  logic [1:0]  ch_ready;
  logic [1:0]  ch_fault;
  logic [1:0]  ch_faultCode;
  logic [31:0] mmu_vAddr;
  logic        mmu_addrValid;
  logic [31:0] mmu_pAddr;
  logic        mmu_ready;
  logic        mmu_tlbMiss;
  logic        mmu_tlbModified;
  logic        mmu_tlbInvalid;
  logic [31:0] db_addr;
  logic [31:0] db_dataOut;
  logic [31:0] db_dataIn;
  logic        db_ready;
  logic [2:0]  db_accessType;
  logic        busy;

  assign ch_accessType = {at[1], at[0]};
  assign ch_addr       = {addr[1], addr[0]};
  assign ch_dataOut    = {wd[1], wd[0]};

  always #5 clk = ~clk;

  mmu_bus_bridge #(
    .NUM_CH      (2),
    .ADDR_W      (32),
    .DATA_W      (32),
    .AT_W        (3),
    .TIMEOUT     (8),
    .KSEG_BYPASS (1)
  ) dut (
    .clk             (clk),
    .res             (res),
    .ch_accessType   (ch_accessType),
    .ch_addr         (ch_addr),
    .ch_dataOut      (ch_dataOut),
    .ch_dataIn       (ch_dataIn),
    .ch_ready        (ch_ready),
    .ch_fault        (ch_fault),
    .ch_faultCode    (ch_faultCode),
    .mmu_vAddr       (mmu_vAddr),
    .mmu_addrValid   (mmu_addrValid),
    .mmu_pAddr       (mmu_pAddr),
    .mmu_ready       (mmu_ready),
    .mmu_tlbMiss     (mmu_tlbMiss),
    .mmu_tlbModified (mmu_tlbModified),
    .mmu_tlbInvalid  (mmu_tlbInvalid),
    .db_addr         (db_addr),
    .db_dataOut      (db_dataOut),
    .db_dataIn       (db_dataIn),
    .db_ready        (db_ready),
    .db_accessType   (db_accessType),
    .busy            (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  int          mmu_lat, db_lat, mmu_cnt, db_cnt;
  logic        f_miss, f_mod, f_inv;
  logic [31:0] mmu_pa, bus_data;
  int          mmu_seen, db_seen, rdy_cnt, flt_cnt, bad;
  logic [31:0] last_va, last_addr, last_wd;
  logic [2:0]  last_at;
  int          gq[$];
  logic [1:0]  g_code;
  logic [31:0] g_din;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MMU and bus responder plus pulse monitor, evaluated on falling edges.
  initial begin
    mmu_ready = 0; mmu_tlbMiss = 0; mmu_tlbModified = 0;
    mmu_tlbInvalid = 0; mmu_pAddr = 0; db_ready = 0; db_dataIn = 0;
    mmu_cnt = 0; db_cnt = 0; mmu_seen = 0; db_seen = 0;
    rdy_cnt = 0; flt_cnt = 0; bad = 0;
    forever begin
      @(negedge clk);
      if (mmu_addrValid) begin
        mmu_seen++;
        last_va = mmu_vAddr;
        if (mmu_cnt == mmu_lat - 1) begin
          mmu_ready = 1; mmu_pAddr = mmu_pa;
          mmu_tlbMiss = f_miss; mmu_tlbModified = f_mod;
          mmu_tlbInvalid = f_inv;
        end
        mmu_cnt++;
      end else begin
        mmu_cnt = 0; mmu_ready = 0;
        mmu_tlbMiss = 0; mmu_tlbModified = 0; mmu_tlbInvalid = 0;
      end
      if (db_accessType != 0) begin
        db_seen++;
        last_addr = db_addr; last_wd = db_dataOut;
        last_at = db_accessType;
        if (db_lat != 0 && db_cnt == db_lat - 1) begin
          db_ready = 1; db_dataIn = bus_data;
        end
        db_cnt++;
      end else begin
        db_cnt = 0; db_ready = 0;
      end
      if (|ch_ready) begin
        rdy_cnt++;
        gq.push_back(ch_ready[1] ? 1 : 0);
      end
      if (|ch_fault) flt_cnt++;
      if ($countones(ch_ready) > 1 || ((|ch_ready) && (|ch_fault))) bad++;
    end
  end

  // Starts just after a rising edge; returns just after a rising edge.
  task automatic req_xact(input int ch, input logic [2:0] a_t,
                          input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [1:0] rf);
    logic tmo;
    at[ch] = a_t; addr[ch] = a; wd[ch] = d;
    cyc = 0; rf = 0; tmo = 0;
    while (rf == 0) begin
      @(negedge clk);
      cyc++;
      if (ch_ready[ch]) rf = 2'b01;
      else if (ch_fault[ch]) rf = 2'b10;
      else if (cyc >= 60) begin rf = 2'b11; tmo = 1; end
    end
    g_code = ch_faultCode;
    g_din  = ch_dataIn;
    chk("wait_bound", 32'(tmo), 0);
    @(posedge clk); #1;
    at[ch] = 0;
  endtask

  int         cyc, c0, c1, snap_r, snap_f;
  logic [1:0] rf, r0, r1;

  initial begin
    at[0] = 0; at[1] = 0; addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
    mmu_lat = 1; db_lat = 1; f_miss = 0; f_mod = 0; f_inv = 0;
    mmu_pa = 0; bus_data = 0;
    res = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dbat", db_accessType, 0);
    chk("rst_dbaddr", db_addr, 0);
    chk("rst_rdy", ch_ready, 0);
    chk("rst_flt", ch_fault, 0);
    chk("rst_code", ch_faultCode, 0);
    chk("rst_mmuv", mmu_addrValid, 0);
    chk("rst_din", ch_dataIn, 0);
    res = 1;
    @(posedge clk); #1;

    // Fairness: both channels request three times back to back.
    mmu_pa = 32'h0000_2000; bus_data = 32'h1111_2222;
    gq.delete();
    fork
      for (int k = 0; k < 3; k++) req_xact(0, AT_RD, 32'h0040_0100, 0, c0, r0);
      for (int k = 0; k < 3; k++) req_xact(1, AT_RD, 32'h0040_0200, 0, c1, r1);
    join
    chk("fair_n", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk($sformatf("fair_g%0d", k), gq[k], k % 2);
    chk("fair_r0", r0, 2'b01);
    chk("fair_r1", r1, 2'b01);

    // Single read with a 2-cycle MMU and 1-cycle bus.
    mmu_lat = 2; db_lat = 1; mmu_pa = 32'h0000_1000; bus_data = 32'hCAFE_F00D;
    req_xact(0, AT_RD, 32'h0040_0000, 0, cyc, rf);
    chk("rd_rf", rf, 2'b01);
    chk("rd_cyc", cyc, 5);
    chk("rd_va", last_va, 32'h0040_0000);
    chk("rd_pa", last_addr, 32'h0000_1000);
    chk("rd_at", last_at, AT_RD);
    chk("rd_din", g_din, 32'hCAFE_F00D);

    // Minimum latency read on ch1.
    mmu_lat = 1; mmu_pa = 32'h0000_3000; bus_data = 32'h1234_5678;
    req_xact(1, AT_RD, 32'h0050_0000, 0, cyc, rf);
    chk("min_cyc", cyc, 4);
    chk("min_din", g_din, 32'h1234_5678);

    // kseg write bypasses the MMU and does not touch ch_dataIn.
    mmu_seen = 0; bus_data = 32'hBAD0_BAD0;
    req_xact(1, AT_WR, 32'h8000_1234, 32'hA5A5_0001, cyc, rf);
    chk("kseg_rf", rf, 2'b01);
    chk("kseg_cyc", cyc, 4);
    chk("kseg_mmu", mmu_seen, 0);
    chk("kseg_pa", last_addr, 32'h0000_1234);
    chk("kseg_wd", last_wd, 32'hA5A5_0001);
    chk("kseg_at", last_at, AT_WR);
    chk("kseg_din", ch_dataIn, 32'h1234_5678);

    // TLB fault priority; faulting channel is not granted again.
    for (int k = 0; k < 3; k++) begin
      f_miss = (k == 0); f_mod = 1; f_inv = (k == 2);
      db_seen = 0;
      req_xact(0, AT_RD, 32'h0060_0000, 0, cyc, rf);
      chk($sformatf("tlb%0d_rf", k), rf, 2'b10);
      chk($sformatf("tlb%0d_cyc", k), cyc, 3);
      chk($sformatf("tlb%0d_code", k), g_code,
          (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd2);
      chk($sformatf("tlb%0d_db", k), db_seen, 0);
      @(negedge clk);
      chk($sformatf("tlb%0d_regrant", k), busy, 0);
      @(posedge clk); #1;
    end
    f_miss = 0; f_mod = 0; f_inv = 0;

    // Bus timeout after 8 S_BUS cycles.
    db_lat = 0; db_seen = 0;
    req_xact(1, AT_RD, 32'h0070_0000, 0, cyc, rf);
    chk("tmo_rf", rf, 2'b10);
    chk("tmo_cyc", cyc, 11);
    chk("tmo_code", g_code, 2'd3);
    chk("tmo_dbn", db_seen, 8);
    chk("tmo_dbat", db_accessType, 0);
    chk("tmo_busy", busy, 0);

    // Requester drops during address conversion.
    mmu_lat = 20; snap_r = rdy_cnt; snap_f = flt_cnt;
    at[0] = AT_RD; addr[0] = 32'h0080_0000;
    repeat (2) @(negedge clk);
    chk("drop_mmuv1", mmu_addrValid, 1);
    at[0] = 0;
    #1 chk("drop_mmuv0", mmu_addrValid, 0);
    @(negedge clk);
    chk("drop_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("drop_pulse", (rdy_cnt - snap_r) + (flt_cnt - snap_f), 0);

    // Reset asserted while in S_BUS.
    mmu_lat = 1; db_lat = 0; snap_r = rdy_cnt; snap_f = flt_cnt;
    @(posedge clk); #1;
    at[0] = AT_RD; addr[0] = 32'h0090_0000;
    repeat (3) @(negedge clk);
    chk("rbus_at", db_accessType, AT_RD);
    res = 0;
    #1;
    chk("rbus_busy", busy, 0);
    chk("rbus_dbat", db_accessType, 0);
    chk("rbus_dbaddr", db_addr, 0);
    chk("rbus_mmuv", mmu_addrValid, 0);
    chk("rbus_din", ch_dataIn, 0);
    at[0] = 0;
    @(negedge clk);
    res = 1;
    repeat (12) @(negedge clk);
    chk("rbus_pulse", (rdy_cnt - snap_r) + (flt_cnt - snap_f), 0);
    chk("rbus_idle", busy, 0);

    chk("onehot", bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
